sw_test_status_mon: RTL and testbench

SW_TEST_STATUS_MON -- requirements
Module: sw_test_status_mon

---
 rtl/sw_test_status_mon.sv | 132 +++++++++++++
 tb/tb_sw_test_status_mon.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_test_status_mon.sv
// Software test status monitor: tracks per-channel boot/test/pass/fail status
// writes and raises a sticky termination request with an overall verdict.
module sw_test_status_mon #(
   parameter int unsigned                 NumChannels   = 2,
   parameter int unsigned                 AddrWidth     = 32,
   parameter logic [AddrWidth-1:0]        StatusAddr    = AddrWidth'(32'h1000_0000),
   parameter int unsigned                 TimeoutCycles = 0
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  clear_i,
   input  logic [NumChannels-1:0]                wr_valid_i,
   input  logic [NumChannels-1:0][AddrWidth-1:0] addr_i,
   input  logic [NumChannels-1:0][15:0]          data_i,
   output logic [NumChannels-1:0][2:0]           chan_state_o,
   output logic                                  test_done_o,
   output logic                                  test_passed_o,
   output logic                                  timeout_o,
   output logic [2:0]                            fail_chan_o
);

   localparam int unsigned StW    = 3;
   localparam int unsigned CodeW  = 16;
   localparam int unsigned IdxW   = 3;
   localparam int unsigned CntW   = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
   localparam bit          WdEn   = (TimeoutCycles != 0);

   localparam logic [StW-1:0] StIdle = StW'(0);
   localparam logic [StW-1:0] StBoot = StW'(1);
   localparam logic [StW-1:0] StTest = StW'(2);
   localparam logic [StW-1:0] StPass = StW'(3);
   localparam logic [StW-1:0] StFail = StW'(4);

   localparam logic [CodeW-1:0] CodeBoot = CodeW'(16'hB090);
   localparam logic [CodeW-1:0] CodeTest = CodeW'(16'h4354);
   localparam logic [CodeW-1:0] CodePass = CodeW'(16'h900D);
   localparam logic [CodeW-1:0] CodeFail = CodeW'(16'hBAAD);

   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);

   logic [NumChannels-1:0][StW-1:0] state_q;
   logic [NumChannels-1:0][StW-1:0] state_d;
   logic [CntW-1:0]                 cnt_q;
   logic                            any_fail;
   logic                            all_pass;
   logic [IdxW-1:0]                 fail_idx;
   logic                            expire;

   // Per-channel status state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: clear wins; Pass/Fail are sticky; unknown codes ignored
   always_comb begin
      state_d = state_q;
      for (int i = 0; i < int'(NumChannels); i++) begin
         if (clear_i) begin
            state_d[i] = StIdle;
         end else if (wr_valid_i[i] && (addr_i[i] == StatusAddr) &&
                      (state_q[i] == StIdle || state_q[i] == StBoot ||
                       state_q[i] == StTest)) begin
            case (data_i[i])
               CodeBoot: state_d[i] = StBoot;
               CodeTest: state_d[i] = StTest;
               CodePass: state_d[i] = StPass;
               CodeFail: state_d[i] = StFail;
               default:  state_d[i] = state_q[i];
            endcase
         end
      end
   end

   // Channel state outputs and aggregate pass/fail decode
   always_comb begin
      chan_state_o = state_q;
      any_fail     = 1'b0;
      all_pass     = 1'b1;
      fail_idx     = '0;
      for (int i = int'(NumChannels) - 1; i >= 0; i--) begin
         if (state_q[i] != StPass) begin
            all_pass = 1'b0;
         end
         if (state_q[i] == StFail) begin
            any_fail = 1'b1;
            fail_idx = IdxW'(i);
         end
      end
   end

   // Watchdog fires on the cycle the counter sits at its last value
   always_comb begin
      expire = WdEn && !test_done_o && (cnt_q == CntLast);
   end

   // Watchdog counter: runs until done, saturates instead of wrapping
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (WdEn && !test_done_o && (cnt_q != CntMax)) begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   // Sticky verdict capture on the first terminating condition
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         test_done_o   <= 1'b0;
         test_passed_o <= 1'b0;
         timeout_o     <= 1'b0;
         fail_chan_o   <= '0;
      end else if (clear_i) begin
         test_done_o   <= 1'b0;
         test_passed_o <= 1'b0;
         timeout_o     <= 1'b0;
         fail_chan_o   <= '0;
      end else if (!test_done_o && (any_fail || all_pass || expire)) begin
         test_done_o   <= 1'b1;
         test_passed_o <= all_pass && !any_fail && !expire;
         timeout_o     <= expire;
         fail_chan_o   <= any_fail ? fail_idx : '0;
      end
   end

endmodule

// File: tb/tb_sw_test_status_mon.sv
// Directed bench for sw_test_status_mon (2 channels, 100-cycle watchdog).
module tb_sw_test_status_mon;

   localparam int unsigned N  = 2;
   localparam int unsigned AW = 32;
   localparam logic [31:0] SA = 32'h1000_0000;

   logic                   clk_i = 1'b0;
   logic                   rst_ni;
   logic                   clear_i;
   logic [N-1:0]           wr_valid_i;
   logic [N-1:0][AW-1:0]   addr_i;
   logic [N-1:0][15:0]     data_i;
   logic [N-1:0][2:0]      chan_state_o;
   logic                   test_done_o;
   logic                   test_passed_o;
   logic                   timeout_o;
   logic [2:0]             fail_chan_o;

   int checks = 0;
   int errors = 0;
   logic [11:0] exp_v;

   sw_test_status_mon #(
      .NumChannels  (N),
      .AddrWidth    (AW),
      .StatusAddr   (SA),
      .TimeoutCycles(100)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .wr_valid_i   (wr_valid_i),
      .addr_i       (addr_i),
      .data_i       (data_i),
      .chan_state_o (chan_state_o),
      .test_done_o  (test_done_o),
      .test_passed_o(test_passed_o),
      .timeout_o    (timeout_o),
      .fail_chan_o  (fail_chan_o)
   );

   always #5 clk_i = ~clk_i;

   // {done, passed, timeout, fail_chan, state1, state0}
   function automatic logic [11:0] snap();
      return {test_done_o, test_passed_o, timeout_o, fail_chan_o,
              chan_state_o[1], chan_state_o[0]};
   endfunction

   function automatic logic [11:0] mk(input logic d, input logic p, input logic t,
                                      input logic [2:0] fc, input logic [2:0] s1,
                                      input logic [2:0] s0);
      return {d, p, t, fc, s1, s0};
   endfunction

   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic idle_inputs();
      wr_valid_i = '0;
      addr_i     = '0;
      data_i     = '0;
      clear_i    = 1'b0;
   endtask

   task automatic set_wr(input int ch, input logic [31:0] a, input logic [15:0] d);
      wr_valid_i[ch] = 1'b1;
      addr_i[ch]     = a;
      data_i[ch]     = d;
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      step();
      idle_inputs();
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk_i);
      exp_v = mk(0, 0, 0, 0, 0, 0);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL reset got=%h exp=%h", snap(), exp_v);
      end
      rst_ni = 1'b1;
   endtask

   task automatic test_timeout();
      repeat (99) step();
      exp_v = mk(0, 0, 0, 0, 0, 0);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL timeout_early got=%h exp=%h", snap(), exp_v);
      end
      step();
      exp_v = mk(1, 0, 1, 0, 0, 0);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL timeout_at_100 got=%h exp=%h", snap(), exp_v);
      end
      set_wr(0, SA, 16'h900D); set_wr(1, SA, 16'h900D);
      step(); idle_inputs(); step();
      exp_v = mk(1, 0, 1, 0, 3, 3);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL timeout_sticky got=%h exp=%h", snap(), exp_v);
      end
   endtask

   task automatic test_pass();
      do_clear();
      exp_v = mk(0, 0, 0, 0, 0, 0);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL clear_state got=%h exp=%h", snap(), exp_v);
      end
      set_wr(0, SA, 16'h4354); step(); idle_inputs();
      set_wr(0, SA, 16'h900D); step(); idle_inputs();
      exp_v = mk(0, 0, 0, 0, 0, 3);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL pass_ch0 got=%h exp=%h", snap(), exp_v);
      end
      set_wr(1, SA, 16'h4354); step(); idle_inputs();
      set_wr(1, SA, 16'h900D); step(); idle_inputs();
      exp_v = mk(0, 0, 0, 0, 3, 3);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL pass_ch1_state got=%h exp=%h", snap(), exp_v);
      end
      step();
      exp_v = mk(1, 1, 0, 0, 3, 3);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL pass_done got=%h exp=%h", snap(), exp_v);
      end
   endtask

   task automatic test_fail();
      do_clear();
      set_wr(0, SA, 16'h4354); set_wr(1, SA, 16'h4354); step(); idle_inputs();
      exp_v = mk(0, 0, 0, 0, 2, 2);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL simul_test got=%h exp=%h", snap(), exp_v);
      end
      set_wr(0, SA, 16'hBAAD); step(); idle_inputs();
      exp_v = mk(0, 0, 0, 0, 2, 4);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL fail_state got=%h exp=%h", snap(), exp_v);
      end
      step();
      exp_v = mk(1, 0, 0, 0, 2, 4);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL fail_done got=%h exp=%h", snap(), exp_v);
      end
      set_wr(1, SA, 16'h900D); step(); idle_inputs(); step();
      exp_v = mk(1, 0, 0, 0, 3, 4);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL fail_sticky got=%h exp=%h", snap(), exp_v);
      end
      // channel 1 failing alone must be reported as index 1
      do_clear();
      set_wr(0, SA, 16'hB090); set_wr(1, SA, 16'hBAAD); step(); idle_inputs(); step();
      exp_v = mk(1, 0, 0, 1, 4, 1);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL fail_ch1 got=%h exp=%h", snap(), exp_v);
      end
      // both failing together reports the lowest index
      do_clear();
      set_wr(0, SA, 16'hBAAD); set_wr(1, SA, 16'hBAAD); step(); idle_inputs(); step();
      exp_v = mk(1, 0, 0, 0, 4, 4);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL fail_both got=%h exp=%h", snap(), exp_v);
      end
   endtask

   task automatic test_ignore();
      do_clear();
      set_wr(0, SA + 32'd4, 16'h900D); step(); idle_inputs();
      set_wr(1, SA, 16'h1234); step(); idle_inputs();
      addr_i[0] = SA; data_i[0] = 16'hBAAD; step(); idle_inputs();
      exp_v = mk(0, 0, 0, 0, 0, 0);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL ignore_writes got=%h exp=%h", snap(), exp_v);
      end
      set_wr(0, SA, 16'h900D); set_wr(1, SA, 16'hB090); step(); idle_inputs();
      set_wr(0, SA, 16'h4354); step(); idle_inputs();
      exp_v = mk(0, 0, 0, 0, 1, 3);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL pass_is_sticky got=%h exp=%h", snap(), exp_v);
      end
   endtask

   task automatic test_clear_priority();
      do_clear();
      set_wr(0, SA, 16'h4354); step(); idle_inputs();
      clear_i = 1'b1; set_wr(0, SA, 16'hBAAD); set_wr(1, SA, 16'hBAAD);
      step(); idle_inputs();
      exp_v = mk(0, 0, 0, 0, 0, 0);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL clear_vs_write got=%h exp=%h", snap(), exp_v);
      end
      step();
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL clear_settled got=%h exp=%h", snap(), exp_v);
      end
   endtask

   task automatic test_fail_and_timeout();
      do_clear();
      repeat (98) step();
      set_wr(1, SA, 16'hBAAD); step(); idle_inputs();
      exp_v = mk(0, 0, 0, 0, 4, 0);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL ft_before got=%h exp=%h", snap(), exp_v);
      end
      step();
      exp_v = mk(1, 0, 1, 1, 4, 0);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL ft_same_cycle got=%h exp=%h", snap(), exp_v);
      end
   endtask

   task automatic test_reset_mid();
      rst_ni = 1'b0;
      #1;
      exp_v = mk(0, 0, 0, 0, 0, 0);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL async_reset got=%h exp=%h", snap(), exp_v);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      set_wr(0, SA, 16'h900D); set_wr(1, SA, 16'h900D); step(); idle_inputs();
      exp_v = mk(0, 0, 0, 0, 3, 3);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL post_reset_state got=%h exp=%h", snap(), exp_v);
      end
      step();
      exp_v = mk(1, 1, 0, 0, 3, 3);
      checks++;
      if (snap() !== exp_v) begin
         errors++; $display("FAIL post_reset_pass got=%h exp=%h", snap(), exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_pass();
      test_fail();
      test_ignore();
      test_clear_priority();
      test_fail_and_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
